// File: rtl/mem_pkg.sv
// Shared load/store definitions: size encodings, responder FSM states, and the
// lane/extension helpers also used by the core's LSU decode.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Size 2'b11 is illegal and reported through the same path as misalignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return |addr_lo;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 4'b0001 << addr_lo;
      SZ_HALF: return addr_lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_align(input logic [31:0] wdata, input logic [1:0] size);
    case (size)
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] addr_lo,
                                              input logic [1:0] size, input logic is_unsigned);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{addr_lo, 3'b000} +: 8];
    h = addr_lo[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: return is_unsigned ? {24'h000000, b} : {{24{b[7]}}, b};
      SZ_HALF: return is_unsigned ? {16'h0000, h} : {{16{h[15]}}, h};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_resp_if.sv
// Request/response bus between the register-file datapath and the data memory.
interface data_mem_resp_if #(
  parameter int COLS = 32
) ();

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [COLS-1:0] req_addr;
  logic [COLS-1:0] req_wdata;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic            rsp_valid;
  logic [COLS-1:0] rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/data_mem_array.sv
// Word-organised data storage: byte-enable synchronous write and registered
// read sharing one clock edge. Contents are not reset.
module data_mem_array #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic                           re,
  input  logic [3:0]                     be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < 4; b++) begin
      if (we && be[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
    end
    if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder: accepts one load/store at a time, performs it after a
// fixed latency, and returns extended load data with a misalignment flag.
module data_mem_resp
  import mem_pkg::*;
#(
  parameter int COLS        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input logic            clk,
  input logic            rst,
  data_mem_resp_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_t          state, state_next;
  logic [3:0]      cnt, cnt_next;
  logic            accept;

  logic            we_q, uns_q;
  logic [1:0]      size_q;
  logic [COLS-1:0] addr_q, wdata_q;

  logic            cur_we;
  logic [1:0]      cur_size;
  logic [COLS-1:0] cur_addr, cur_wdata;
  logic            cur_err, enter_resp, mem_we, mem_re;

  logic [31:0]     arr_rdata, load_val;
  logic [COLS-1:0] rdata_q;
  logic            resp_err, resp_load;

  assign accept = bus.req_valid && (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= bus.req_we;
      uns_q   <= bus.req_unsigned;
      size_q  <= bus.req_size;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = 4'(LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (cnt == '0) state_next = RESP;
        else           cnt_next   = cnt - 4'd1;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // With LATENCY==1 the edge entering RESP is the accepting edge, so the array
  // must see the live bus fields rather than the not-yet-latched copies.
  always_comb begin
    if (state == IDLE) begin
      cur_we    = bus.req_we;
      cur_size  = bus.req_size;
      cur_addr  = bus.req_addr;
      cur_wdata = bus.req_wdata;
    end else begin
      cur_we    = we_q;
      cur_size  = size_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
    end
  end

  assign enter_resp = (state_next == RESP);
  assign cur_err    = is_misaligned(cur_size, cur_addr[1:0]);
  assign mem_we     = enter_resp && cur_we && !cur_err;
  assign mem_re     = enter_resp && !cur_we && !cur_err;

  data_mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .be    (byte_en(cur_size, cur_addr[1:0])),
    .idx   (cur_addr[IDX_W+1:2]),
    .wdata (store_align(cur_wdata[31:0], cur_size)),
    .rdata (arr_rdata)
  );

  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_q[COLS-1:2], cur_addr[COLS-1:IDX_W+2]};

  // The array holds the raw word captured on the RESP entry edge; extension is
  // applied during RESP and the result is kept in rdata_q for later cycles.
  assign resp_err  = (state == RESP) && is_misaligned(size_q, addr_q[1:0]);
  assign resp_load = (state == RESP) && !we_q && !resp_err;
  assign load_val  = load_extend(arr_rdata, addr_q[1:0], size_q, uns_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            rdata_q <= '0;
    else if (resp_load) rdata_q <= COLS'(load_val);
  end

  always_comb begin
    bus.req_ready = (state == IDLE);
    bus.rsp_valid = (state == RESP);
    bus.rsp_err   = resp_err;
    bus.rsp_rdata = resp_load ? COLS'(load_val) : rdata_q;
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: a vector table on a LATENCY=2 instance,
// a reset-abort sequence, and a short run on a LATENCY=1 instance.
module tb_data_mem_resp;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_mem_resp_if #(.COLS(32)) bus2 ();
  data_mem_resp_if #(.COLS(32)) bus1 ();

  data_mem_resp #(.COLS(32), .DEPTH_WORDS(1024), .LATENCY(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  data_mem_resp #(.COLS(32), .DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;

  assign bus2.req_valid    = req_valid & ~sel;
  assign bus1.req_valid    = req_valid & sel;
  assign bus2.req_we       = req_we;
  assign bus1.req_we       = req_we;
  assign bus2.req_addr     = req_addr;
  assign bus1.req_addr     = req_addr;
  assign bus2.req_wdata    = req_wdata;
  assign bus1.req_wdata    = req_wdata;
  assign bus2.req_size     = req_size;
  assign bus1.req_size     = req_size;
  assign bus2.req_unsigned = req_unsigned;
  assign bus1.req_unsigned = req_unsigned;

  logic        obs_ready, obs_valid, obs_err;
  logic [31:0] obs_rdata;
  assign obs_ready = sel ? bus1.req_ready : bus2.req_ready;
  assign obs_valid = sel ? bus1.rsp_valid : bus2.rsp_valid;
  assign obs_err   = sel ? bus1.rsp_err   : bus2.rsp_err;
  assign obs_rdata = sel ? bus1.rsp_rdata : bus2.rsp_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] exp_rdata;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [1:0] size, input logic uns,
                              input logic [31:0] exp_rdata, input logic exp_err, input string name);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.size = size; v.uns = uns;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.name = name;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Entered and left at a negedge with the selected DUT idle.
  task automatic do_req(input logic s, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                        input logic [31:0] exp_rdata, input logic exp_err, input string name);
    int          n;
    bit          seen;
    logic [31:0] got;
    int          exp_lat;
    exp_lat = s ? 1 : 2;
    sel = s;
    req_we = we; req_addr = addr; req_wdata = wdata; req_size = size; req_unsigned = uns;
    #1;
    chk({name, ".ready_idle"}, 32'(obs_ready), 32'd1);
    req_valid = 1'b1;
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      req_valid = 1'b0;
      chk({name, ".ready_busy"}, 32'(obs_ready), 32'd0);
      if (obs_valid) seen = 1'b1;
    end
    chk({name, ".rsp_seen"}, 32'(seen), 32'd1);
    chk({name, ".latency"}, 32'(n), 32'(exp_lat));
    chk({name, ".rdata"}, obs_rdata, exp_rdata);
    chk({name, ".err"}, 32'(obs_err), 32'(exp_err));
    got = obs_rdata;
    @(negedge clk);
    chk({name, ".pulse"}, 32'(obs_valid), 32'd0);
    chk({name, ".hold"}, obs_rdata, got);
  endtask

  initial begin
    int pulses;

    vecs.push_back(mk(1, 32'h10,   32'hDEADBEEF, SZ_WORD, 0, 32'h00000000, 0, "sw_10"));
    vecs.push_back(mk(0, 32'h10,   32'h0,        SZ_WORD, 0, 32'hDEADBEEF, 0, "lw_10"));
    vecs.push_back(mk(1, 32'h10,   32'h00000000, SZ_WORD, 0, 32'hDEADBEEF, 0, "sw_10_zero"));
    vecs.push_back(mk(1, 32'h13,   32'h12345680, SZ_BYTE, 0, 32'hDEADBEEF, 0, "sb_13"));
    vecs.push_back(mk(0, 32'h13,   32'h0,        SZ_BYTE, 0, 32'hFFFFFF80, 0, "lb_13"));
    vecs.push_back(mk(0, 32'h13,   32'h0,        SZ_BYTE, 1, 32'h00000080, 0, "lbu_13"));
    vecs.push_back(mk(0, 32'h10,   32'h0,        SZ_WORD, 0, 32'h80000000, 0, "lw_10_b"));
    vecs.push_back(mk(1, 32'h20,   32'h00000000, SZ_WORD, 0, 32'h80000000, 0, "sw_20_zero"));
    vecs.push_back(mk(1, 32'h22,   32'hABCD8001, SZ_HALF, 0, 32'h80000000, 0, "sh_22"));
    vecs.push_back(mk(0, 32'h22,   32'h0,        SZ_HALF, 0, 32'hFFFF8001, 0, "lh_22"));
    vecs.push_back(mk(0, 32'h22,   32'h0,        SZ_HALF, 1, 32'h00008001, 0, "lhu_22"));
    vecs.push_back(mk(0, 32'h20,   32'h0,        SZ_WORD, 0, 32'h80010000, 0, "lw_20"));
    vecs.push_back(mk(1, 32'h04,   32'hCAFEF00D, SZ_WORD, 0, 32'h80010000, 0, "sw_04"));
    vecs.push_back(mk(0, 32'h06,   32'h0,        SZ_WORD, 0, 32'h80010000, 1, "lw_06_mis"));
    vecs.push_back(mk(1, 32'h05,   32'h00001111, SZ_HALF, 0, 32'h80010000, 1, "sh_05_mis"));
    vecs.push_back(mk(0, 32'h04,   32'h0,        SZ_WORD, 0, 32'hCAFEF00D, 0, "lw_04_intact"));
    vecs.push_back(mk(0, 32'h04,   32'h0,        2'b11,   0, 32'hCAFEF00D, 1, "ld_size11"));
    vecs.push_back(mk(1, 32'h1004, 32'h12345678, SZ_WORD, 0, 32'hCAFEF00D, 0, "sw_wrap"));
    vecs.push_back(mk(0, 32'h04,   32'h0,        SZ_WORD, 0, 32'h12345678, 0, "lw_04_wrap"));
    vecs.push_back(mk(1, 32'h11,   32'h0000007F, SZ_BYTE, 0, 32'h12345678, 0, "sb_11"));
    vecs.push_back(mk(0, 32'h11,   32'h0,        SZ_BYTE, 0, 32'h0000007F, 0, "lb_11"));
    vecs.push_back(mk(0, 32'h10,   32'h0,        SZ_WORD, 0, 32'h80007F00, 0, "lw_10_c"));
    vecs.push_back(mk(0, 32'h20,   32'h0,        SZ_WORD, 1, 32'h80010000, 0, "lw_20_uns"));
    vecs.push_back(mk(1, 32'h30,   32'h55AA55AA, SZ_WORD, 0, 32'h80010000, 0, "sw_30"));

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.ready2", 32'(bus2.req_ready), 32'd1);
    chk("rst.valid2", 32'(bus2.rsp_valid), 32'd0);
    chk("rst.rdata2", bus2.rsp_rdata, 32'h0);
    chk("rst.err2",   32'(bus2.rsp_err), 32'd0);
    chk("rst.valid1", 32'(bus1.rsp_valid), 32'd0);
    chk("rst.rdata1", bus1.rsp_rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      do_req(1'b0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].uns,
             vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].name);
    end

    // Reset while a store to 0x30 waits: the write must be abandoned.
    sel = 1'b0;
    req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h0BADF00D; req_size = SZ_WORD;
    req_unsigned = 1'b0; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort.in_wait", 32'(bus2.req_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("abort.ready", 32'(bus2.req_ready), 32'd1);
    chk("abort.valid", 32'(bus2.rsp_valid), 32'd0);
    chk("abort.rdata", bus2.rsp_rdata, 32'h0);
    chk("abort.err",   32'(bus2.rsp_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus2.rsp_valid) pulses++;
    end
    chk("abort.no_rsp", 32'(pulses), 32'd0);
    chk("abort.ready_after", 32'(bus2.req_ready), 32'd1);
    do_req(1'b0, 1'b0, 32'h30, 32'h0, SZ_WORD, 1'b0, 32'h55AA55AA, 1'b0, "lw_30_after_abort");

    // LATENCY=1 instance
    do_req(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, SZ_WORD, 1'b0, 32'h00000000, 1'b0, "l1_sw_10");
    do_req(1'b1, 1'b0, 32'h10, 32'h0,        SZ_WORD, 1'b0, 32'hDEADBEEF, 1'b0, "l1_lw_10");
    do_req(1'b1, 1'b0, 32'h06, 32'h0,        SZ_WORD, 1'b0, 32'hDEADBEEF, 1'b1, "l1_lw_06_mis");
    do_req(1'b1, 1'b0, 32'h12, 32'h0,        SZ_HALF, 1'b0, 32'hFFFFDEAD, 1'b0, "l1_lh_12");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
